tty_uart_tx: RTL



---
 rtl/tty_pkg.sv | 15 +
 rtl/tty_fifo.sv | 54 +++++
 rtl/tty_uart_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tty_pkg.sv
// Shared types and constants for the TTY UART transmitter.
package tty_pkg;

  localparam int unsigned TTY_DATA_W     = 7;
  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned FRAME_BITS     = 10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tty_state_e;

endpackage

// File: rtl/tty_fifo.sv
// Synchronous FIFO; pointers carry one extra wrap bit so count = wptr - rptr.
module tty_fifo #(
  parameter int unsigned Width   = 8,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [Width-1:0]   wdata_i,
  input  logic               pop_i,
  output logic [Width-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [FIFO_AW:0]   count_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [Width-1:0] mem_q [Depth];
  logic [FIFO_AW:0] wptr_q, wptr_d;
  logic [FIFO_AW:0] rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == (FIFO_AW + 1)'(Depth));
  assign empty_o = (count_o == '0);
  assign rdata_o = mem_q[rptr_q[FIFO_AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[FIFO_AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tty_uart_tx.sv
// TTY write port to 8N1 UART: buffers characters and serializes them back-to-back.
module tty_uart_tx
  import tty_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 250,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TTY_DATA_W-1:0] tty_data_i,
  input  logic                  tty_we_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LastBit  = 3'(UART_DATA_BITS - 1);

  tty_state_e                state_q, state_d;
  logic [BaudW-1:0]          baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      ovf_q, ovf_d;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
  logic [CntW-1:0]           fifo_count, count_d;
  logic                      baud_tick;

  assign fifo_push = tty_we_i & ~fifo_full;
  assign baud_tick = (baud_q == BaudLast);

  tty_fifo #(
    .Width   (UART_DATA_BITS),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .wdata_i ({1'b0, tty_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          bit_d    = '0;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == LastBit) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_tick) begin
          baud_d = '0;
          // Chain straight into the next start bit when more text is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            bit_d    = '0;
            tx_d     = 1'b0;
            state_d  = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase

    count_d = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop & ~fifo_empty);
    busy_d  = (state_d != StIdle) | (count_d != '0);
    ovf_d   = ovf_q | (tty_we_i & fifo_full);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign full_o     = fifo_full;
  assign overflow_o = ovf_q;

endmodule
